// File: rtl/uart_tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_sched_pkg
//   Shared types and constants for the UART transmit scheduler.
//   - sched_state_t   : scheduler FSM states
//   - BYTE_W          : width of one transmitted byte
//   - TIMEOUT_CYC_DEF : default watchdog limit, used only when the design is
//                       built with UART_TX_SCHED_TIMEOUT_EN defined. It is
//                       above one 10-bit frame at 2605 clk per bit.
// ---------------------------------------------------------------------------
package uart_tx_sched_pkg;

  localparam int BYTE_W          = 8;
  localparam int TIMEOUT_CYC_DEF = 40000;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_CLR,
    WAIT_SET,
    ACK
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The winner is the first set request bit
//   at or above i_ptr, searching upward and wrapping past NUM_REQ-1 to 0.
//   The pointer register itself lives in the parent.
// Ports:
//   i_req   [NUM_REQ-1:0] request vector
//   i_ptr   [GID_W-1:0]   highest-priority index (must be < NUM_REQ)
//   o_grant [NUM_REQ-1:0] one-hot grant, zero when nothing requests
//   o_id    [GID_W-1:0]   encoded index of the grant (0 when none)
//   o_any                 at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GID_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [GID_W-1:0]   o_id,
  output logic               o_any
);

  logic             w_found;
  logic [GID_W-1:0] w_idx;

  // Index of the k-th candidate after the pointer, wrapped into 0..NUM_REQ-1.
  function automatic int wrap_idx(input int p, input int k);
    return (p + k >= NUM_REQ) ? (p + k - NUM_REQ) : (p + k);
  endfunction

  assign o_any = |i_req;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = GID_W'(wrap_idx(int'(i_ptr), k));
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//   Shares one UART transmitter between NUM_REQ byte producers. In IDLE a
//   round-robin winner is picked and its byte latched; LAUNCH pulses trmt;
//   the FSM then follows tx_done through clear (WAIT_CLR) and set
//   (WAIT_SET) and pulses ack for the winner (ACK) before returning to IDLE.
//
// Optional feature (macro UART_TX_SCHED_TIMEOUT_EN):
//   A 16-bit watchdog counts WAIT_CLR/WAIT_SET cycles. On reaching
//   TIMEOUT_CYC it sets the sticky err flag and forces ACK so the requester
//   is released. Without the macro err is tied 0 and waits are unbounded.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req          [NUM_REQ-1:0] level requests
//   req_data     [8*NUM_REQ-1:0] byte i on bits [8i+7:8i]
//   ack          [NUM_REQ-1:0] one-cycle "byte sent" pulse to the winner
//   busy         high in every state except IDLE
//   gnt_id       [GID_W-1:0] current/last granted requester
//   trmt         one-cycle start pulse to the transmitter
//   tx_data      [7:0] latched byte for the transmitter
//   tx_done      transmitter done flag
//   err          sticky watchdog error
// ---------------------------------------------------------------------------
import uart_tx_sched_pkg::*;

module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = $clog2(NUM_REQ)
`ifdef UART_TX_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [GID_W-1:0]          gnt_id,
  output logic                      trmt,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      err
);

  sched_state_t        r_state;
  sched_state_t        w_next;
  logic [GID_W-1:0]    r_ptr;
  logic [GID_W-1:0]    r_gnt_id;
  logic [BYTE_W-1:0]   r_tx_data;
  logic [NUM_REQ-1:0]  w_grant;
  logic [GID_W-1:0]    w_id;
  logic                w_any;
  logic [BYTE_W-1:0]   w_sel_byte;
  logic                w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_id),
    .o_any   (w_any)
  );

  // One-hot grant makes the byte select a plain AND-OR.
  always_comb begin
    w_sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel_byte = w_sel_byte | req_data[i*BYTE_W +: BYTE_W];
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;
  logic        w_counting;

  assign w_counting = (r_state == WAIT_CLR) || (r_state == WAIT_SET);
  // Fires on the TIMEOUT_CYC-th waiting cycle; err and ACK appear one later.
  assign w_timeout  = w_counting && (r_cnt == 16'(TIMEOUT_CYC - 1));
  assign err        = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == LAUNCH) r_cnt <= '0;
      else if (w_counting)   r_cnt <= r_cnt + 16'd1;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_any) w_next = LAUNCH;
      LAUNCH:   w_next = WAIT_CLR;
      // WAIT_CLR keeps a stale done=1 from ending the transfer early.
      WAIT_CLR: if (w_timeout) w_next = ACK;
                else if (!tx_done) w_next = WAIT_SET;
      WAIT_SET: if (w_timeout || tx_done) w_next = ACK;
      ACK:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt_id  <= '0;
      r_tx_data <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_gnt_id  <= w_id;
        r_tx_data <= w_sel_byte;
      end
      if (r_state == ACK) begin
        r_ptr <= (r_gnt_id == GID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
      end
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    ack = '0;
    if (r_state == ACK) ack[r_gnt_id] = 1'b1;
  end

  assign trmt    = (r_state == LAUNCH);
  assign busy    = (r_state != IDLE);
  assign gnt_id  = r_gnt_id;
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//   Self-checking bench for uart_tx_sched (NUM_REQ=4). The bench plays the
//   UART transmitter (tx_done clear-then-set) and keeps a transaction-level
//   model: a round-robin pointer and a "first set bit at/after pointer" pick.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  gnt_id;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;
  logic exp_err = 1'b0;

  uart_tx_sched #(
    .NUM_REQ (4)
`ifdef UART_TX_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYC (100)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .gnt_id   (gnt_id),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after p, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transfer, entered and left at a negedge with the DUT idle.
  // hold_hi: extra cycles the transmitter keeps done=1 after trmt.
  // dly:     cycles done stays 0. drop: req bits released in WAIT_SET.
  task automatic do_xfer(input logic [3:0] pat, input logic [31:0] data,
                         input logic [3:0] drop, input int hold_hi,
                         input int dly, output int got);
    int         exp;
    logic [7:0] exp_byte;
    logic [3:0] exp_ack;
    req_data = data;
    req      = pat;
    exp      = rr_pick(pat, m_ptr);
    exp_byte = data[8*exp +: 8];
    exp_ack  = 4'(1 << exp);
    step();
    got = int'(gnt_id);
    check("launch_trmt", trmt, 1);
    check("launch_busy", busy, 1);
    check("gnt_id", gnt_id, exp);
    check("tx_data", tx_data, exp_byte);
    check("launch_ack", ack, 0);
    req_data = $urandom;
    repeat (hold_hi) begin
      step();
      check("clr_wait", {trmt, ack, busy}, 6'b000001);
    end
    step();
    check("trmt_single", trmt, 0);
    tx_done = 1'b0;
    req     = pat & ~drop;
    repeat (dly) begin
      step();
      check("set_wait", {trmt, ack, busy}, 6'b000001);
    end
    tx_done = 1'b1;
    step();
    check("ack", ack, exp_ack);
    check("ack_busy", busy, 1);
    check("ack_gnt", gnt_id, exp);
    check("err", err, exp_err);
    m_ptr = (exp + 1) % 4;
    step();
    check("idle_after", {trmt, ack, busy}, 6'b000000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int rr_order [5] = '{0, 1, 2, 3, 0};

    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", {ack, busy, gnt_id, trmt, tx_data, err}, 0);
    rst = 1'b0;
    step();
    check("post_reset_idle", {ack, busy, trmt}, 0);

    // Round-robin with everybody requesting.
    for (int i = 0; i < 5; i++) begin
      do_xfer(4'hF, 32'h44332211, 4'h0, 0, 3, got);
      check("rr_order", got, rr_order[i]);
    end

    // Single request, byte A5.
    do_xfer(4'b0001, 32'h000000A5, 4'h0, 0, 10, got);
    check("single_tx", tx_data, 8'hA5);

    // Fairness after pointer move: serve 2, then 0 beats 2, then 2.
    do_xfer(4'b0100, $urandom, 4'h0, 0, 2, got);
    do_xfer(4'b0101, $urandom, 4'h0, 0, 2, got);
    check("fair_wrap", got, 0);
    do_xfer(4'b0101, $urandom, 4'h0, 0, 2, got);
    check("fair_next", got, 2);

    // Requester 1 drops in WAIT_SET; still acked, never regranted.
    do_xfer(4'b0010, $urandom, 4'b0010, 1, 4, got);
    repeat (4) begin
      step();
      check("no_regrant", {trmt, busy}, 2'b00);
    end

    // No requests: nothing moves.
    req = '0;
    repeat (5) begin
      step();
      check("idle_quiet", {trmt, ack, busy}, 6'b000000);
    end

    // Randomised transfers against the model.
    for (int i = 0; i < 40; i++) begin
      do_xfer(4'($urandom_range(1, 15)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2), $urandom_range(1, 6), got);
    end
    req = '0;
    step();

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Transmitter never clears done: watchdog releases the requester.
    begin
      int         exp;
      logic [3:0] exp_ack;
      req_data = $urandom;
      req      = 4'b0110;
      exp      = rr_pick(4'b0110, m_ptr);
      exp_ack  = 4'(1 << exp);
      step();
      check("to_launch", trmt, 1);
      for (int c = 1; c <= 100; c++) begin
        step();
        if (c == 1 || c == 100) check("to_early", {err, ack}, 5'b00000);
      end
      step();
      check("to_err", err, 1);
      check("to_ack", ack, exp_ack);
      exp_err = 1'b1;
      m_ptr   = (exp + 1) % 4;
      req     = '0;
      step();
      check("to_idle", busy, 0);
      do_xfer(4'hF, $urandom, 4'h0, 0, 2, got);
      check("to_next", got, m_ptr == 0 ? 3 : m_ptr - 1);
      req = '0;
    end
`endif

    // Reset mid-transfer, with the pointer sitting at 2 beforehand.
    do_xfer(4'b0010, $urandom, 4'h0, 0, 2, got);
    req_data = $urandom;
    req      = 4'b0100;
    step();
    check("mid_gnt", gnt_id, 2);
    step();
    tx_done = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rst_async", {ack, busy, gnt_id, trmt, tx_data, err}, 0);
    step();
    check("rst_hold", {ack, busy, gnt_id, trmt, tx_data, err}, 0);
    rst     = 1'b0;
    tx_done = 1'b1;
    req     = '0;
    m_ptr   = 0;
    exp_err = 1'b0;
    step();
    check("rst_no_trmt", {trmt, ack, busy}, 6'b000000);
    do_xfer(4'b1010, $urandom, 4'h0, 0, 2, got);
    check("rst_ptr0", got, 1);
    do_xfer(4'b1000, $urandom, 4'h0, 0, 2, got);
    check("rst_req3", got, 3);
    req = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
